// File: rtl/mem_data_interface.sv
// Memory-side data path stage: holds MAR/MDR, drives the RAM request/ack
// handshake with wait states and a timeout, and presents MDR to the bus mux.
// All state changes on the falling edge of clock; clear is an asynchronous,
// active-low reset.
module mem_data_interface #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] BusMuxOut,
   input  logic                  MARin,
   input  logic                  MDRin,
   input  logic                  Read,
   input  logic                  Write,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [DATA_WIDTH-1:0] BusMuxInMDR,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   // Counter must be able to hold the value TIMEOUT itself.
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] mar_reg,   mar_next;
   logic [DATA_WIDTH-1:0] mdr_reg,   mdr_next;
   logic [CW-1:0]         cnt_reg,   cnt_next;
   logic                  err_reg,   err_next;

   // State and datapath registers, falling-edge, async active-low clear.
   always_ff @(negedge clock or negedge clear) begin
      if (!clear) begin
         state_reg <= IDLE;
         mar_reg   <= '0;
         mdr_reg   <= '0;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         mar_reg   <= mar_next;
         mdr_reg   <= mdr_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
      end
   end

   // Next-state logic: register loads only in IDLE so address and write data
   // stay frozen for the whole handshake; ack beats timeout on the same edge.
   always_comb begin
      state_next = state_reg;
      mar_next   = mar_reg;
      mdr_next   = mdr_reg;
      cnt_next   = cnt_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (MARin) mar_next = BusMuxOut[ADDR_WIDTH-1:0];
            if (MDRin) mdr_next = BusMuxOut;
            if (Read) begin
               state_next = RD_WAIT;
               cnt_next   = '0;
               err_next   = 1'b0;
            end else if (Write) begin
               state_next = WR_WAIT;
               cnt_next   = '0;
               err_next   = 1'b0;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (mem_ack) begin
               state_next = DONE;
               if (state_reg == RD_WAIT) mdr_next = mem_rdata;
            end else if (cnt_reg == CNT_MAX) begin
               state_next = DONE;
               err_next   = 1'b1;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded purely from registered state.
   assign mem_req     = (state_reg == RD_WAIT) || (state_reg == WR_WAIT);
   assign mem_we      = (state_reg == WR_WAIT);
   assign done        = (state_reg == DONE);
   assign busy        = (state_reg != IDLE);
   assign err         = err_reg;
   assign mem_addr    = mar_reg;
   assign mem_wdata   = mdr_reg;
   assign BusMuxInMDR = mdr_reg;

endmodule

// File: tb/tb_mem_data_interface.sv
// Self-checking bench for mem_data_interface: table of IDLE-phase vectors,
// hand-written corner sequences, then randomized transactions checked against
// a transaction-level model (latency and result derived from the ack delay).
module tb_mem_data_interface;

   localparam int DW  = 32;
   localparam int AW  = 9;
   localparam int TMO = 15;

   logic          clock;
   logic          clear;
   logic [DW-1:0] BusMuxOut;
   logic          MARin, MDRin, Read, Write;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, BusMuxInMDR;
   logic          busy, done, err;

   int checks = 0;
   int errors = 0;
   int xfer_no = 0;

   // Transaction-level model state.
   logic [AW-1:0] mar_m;
   logic [DW-1:0] mdr_m;
   logic          err_m;

   typedef struct {
      logic          marin;
      logic          mdrin;
      logic          ack;
      logic [DW-1:0] bus;
      logic [DW-1:0] rdata;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_mdr;
   } vec_t;

   vec_t vecs[6];

   mem_data_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
      .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut),
      .MARin(MARin), .MDRin(MDRin), .Read(Read), .Write(Write),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .BusMuxInMDR(BusMuxInMDR),
      .busy(busy), .done(done), .err(err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Pass one active (falling) edge, then settle before sampling.
   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      MARin = 0; MDRin = 0; Read = 0; Write = 0; mem_ack = 0;
   endtask

   task automatic do_load(input bit marin, input bit mdrin, input logic [DW-1:0] bus);
      MARin = marin; MDRin = mdrin; BusMuxOut = bus;
      tick();
      MARin = 0; MDRin = 0;
      if (marin) mar_m = bus[AW-1:0];
      if (mdrin) mdr_m = bus;
      check("load_addr", mem_addr, mar_m);
      check("load_mdr", BusMuxInMDR, mdr_m);
   endtask

   // One transfer from IDLE; ack raised 'delay' edges after the start edge,
   // or never if delay exceeds the timeout.
   task automatic run_xfer(input bit rd, input bit wr, input int delay,
                           input logic [DW-1:0] rdata, input bit junk);
      int eff;
      bit acked;
      acked = (delay <= TMO);
      eff   = acked ? delay : TMO;
      Read = rd; Write = wr;
      tick();
      Read = 0; Write = 0;
      for (int k = 0; k <= eff; k++) begin
         check("wait_req", mem_req, 1);
         check("wait_we", mem_we, !rd);
         check("wait_addr", mem_addr, mar_m);
         check("wait_wdata", mem_wdata, mdr_m);
         check("wait_busy", busy, 1);
         check("wait_done", done, 0);
         check("wait_err", err, 0);
         mem_ack   = (k == delay);
         mem_rdata = (k == delay) ? rdata : $urandom;
         if (junk) begin
            MARin = 1'($urandom); MDRin = 1'($urandom); BusMuxOut = $urandom;
         end
         tick();
      end
      mem_ack = 0;
      if (rd && acked) mdr_m = rdata;
      err_m = !acked;
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      check("done_req", mem_req, 0);
      check("done_err", err, err_m);
      check("done_mdr", BusMuxInMDR, mdr_m);
      check("done_addr", mem_addr, mar_m);
      // A late ack while in DONE must be ignored.
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      tick();
      idle_inputs();
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_err", err, err_m);
      check("idle_mdr", BusMuxInMDR, mdr_m);
      check("idle_addr", mem_addr, mar_m);
      xfer_no++;
      $display("xfer %0d: %s addr=%h delay=%0d mdr=%h err=%0b",
               xfer_no, rd ? "read " : "write", mar_m, delay, mdr_m, err_m);
   endtask

   initial begin
      vecs[0] = '{1, 0, 0, 32'h0000_0012, 32'h0, 9'h012, 32'h0000_0000};
      vecs[1] = '{0, 1, 0, 32'h0000_1234, 32'h0, 9'h012, 32'h0000_1234};
      vecs[2] = '{1, 1, 0, 32'hFFFF_F1FF, 32'h0, 9'h1FF, 32'hFFFF_F1FF};
      vecs[3] = '{0, 0, 1, 32'h0, 32'hFFFF_FFFF, 9'h1FF, 32'hFFFF_F1FF};
      vecs[4] = '{1, 0, 0, 32'h0000_00A5, 32'h0, 9'h0A5, 32'hFFFF_F1FF};
      vecs[5] = '{0, 1, 0, 32'h55AA_55AA, 32'h0, 9'h0A5, 32'h55AA_55AA};

      idle_inputs();
      BusMuxOut = '0; mem_rdata = '0;
      clear = 1;
      #2 clear = 0;
      tick();
      tick();
      check("rst_req", mem_req, 0);
      check("rst_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_mdr", BusMuxInMDR, 0);
      clear = 1;

      // IDLE-phase vector table: loads, truncation, stray ack.
      for (int i = 0; i < 6; i++) begin
         MARin = vecs[i].marin; MDRin = vecs[i].mdrin; mem_ack = vecs[i].ack;
         BusMuxOut = vecs[i].bus; mem_rdata = vecs[i].rdata;
         tick();
         idle_inputs();
         check("vec_addr", mem_addr, vecs[i].exp_addr);
         check("vec_mdr", BusMuxInMDR, vecs[i].exp_mdr);
         check("vec_busy", busy, 0);
         check("vec_done", done, 0);
         $display("vector %0d: addr=%h mdr=%h", i, mem_addr, BusMuxInMDR);
      end

      // Reset in the middle of a read drops the request at once.
      Read = 1;
      tick();
      Read = 0;
      check("mid_req_before", mem_req, 1);
      #2 clear = 0;
      #1;
      check("mid_req", mem_req, 0);
      check("mid_addr", mem_addr, 0);
      check("mid_busy", busy, 0);
      mem_ack = 1; mem_rdata = 32'h1234_5678;
      tick();
      clear = 1;
      tick();
      mem_ack = 0;
      check("mid_late_mdr", BusMuxInMDR, 0);
      check("mid_late_done", done, 0);
      check("mid_late_busy", busy, 0);
      mar_m = '0; mdr_m = '0; err_m = 0;
      $display("reset mid-read: req=%0b addr=%h mdr=%h", mem_req, mem_addr, BusMuxInMDR);

      // Zero-wait read.
      do_load(1, 0, 32'h0000_0012);
      run_xfer(1, 0, 0, 32'hDEAD_BEEF, 0);

      // Write with three wait states and junk register pulses mid-transfer.
      do_load(0, 1, 32'h0000_1234);
      do_load(1, 0, 32'h0000_01FF);
      run_xfer(0, 1, 3, 32'h0, 1);

      // Timeout read, err sticky in IDLE, then cleared by the next read.
      do_load(0, 1, 32'h55AA_55AA);
      run_xfer(1, 0, 99, 32'h0, 0);
      tick();
      check("err_sticky", err, 1);
      check("err_mdr_kept", BusMuxInMDR, 32'h55AA_55AA);
      run_xfer(1, 0, 0, 32'hCAFE_F00D, 0);
      check("err_cleared", err, 0);

      // Read and Write together: read wins, no write afterwards.
      run_xfer(1, 1, 2, 32'h0BAD_CAFE, 0);
      tick();
      check("rw_no_write_busy", busy, 0);
      check("rw_no_write_req", mem_req, 0);

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         int op;
         do_load(1'($urandom), 1'($urandom), $urandom);
         if ($urandom_range(0, 3) == 0) begin
            mem_ack = 1; mem_rdata = $urandom;
            tick();
            mem_ack = 0;
            check("stray_mdr", BusMuxInMDR, mdr_m);
            check("stray_busy", busy, 0);
         end
         op = $urandom_range(0, 2);
         run_xfer(op != 1, op != 0, $urandom_range(0, TMO + 3), $urandom, 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
